// File: rtl/rf_write_ctrl.sv
// Register-file write-port controller: two 2-deep writeback queues (ALU, MEM)
// arbitrated round-robin onto one registered write port. Optional RF_CLEAR_EN adds a post-reset zero sweep.
//
// state | meaning
// CLEAR | post-reset sweep writing zero to every register (RF_CLEAR_EN only)
// RUN   | normal operation, queue heads arbitrated onto the write port

module rf_write_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int NREGS  = 2**ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_wr_vld,
   input  logic [ADDR_W-1:0] alu_wr_addr,
   input  logic [DATA_W-1:0] alu_wr_data,
   output logic              alu_wr_rdy,
   input  logic              mem_wr_vld,
   input  logic [ADDR_W-1:0] mem_wr_addr,
   input  logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_wr_rdy,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_dst_addr,
   output logic [DATA_W-1:0] rf_dst,
   output logic [NREGS-1:0]  pend,
   output logic              busy
);

   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   // index 0 = ALU source, index 1 = MEM source
   logic [ADDR_W-1:0] q_addr [2][2];
   logic [DATA_W-1:0] q_data [2][2];
   logic              q_rd   [2];
   logic [1:0]        q_cnt  [2];

   logic              in_vld  [2];
   logic [ADDR_W-1:0] in_addr [2];
   logic [DATA_W-1:0] in_data [2];

   logic              rdy      [2];
   logic              push     [2];
   logic              pop      [2];
   logic              head_vld [2];
   logic              wr_ptr   [2];

   logic              last_grant;
   logic              grant_alu;
   logic              grant_mem;
   logic              grant_src;
   logic              accept_ok;
   logic              run;
   logic              clearing;
   logic [ADDR_W-1:0] clr_addr;

   assign in_vld[0]  = alu_wr_vld;
   assign in_addr[0] = alu_wr_addr;
   assign in_data[0] = alu_wr_data;
   assign in_vld[1]  = mem_wr_vld;
   assign in_addr[1] = mem_wr_addr;
   assign in_data[1] = mem_wr_data;

`ifdef RF_CLEAR_EN
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] clr_cnt;
   logic              busy_r;

   // busy_r lags the state by one cycle so it stays high while the
   // last sweep write is on the port
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_cnt <= '0;
         busy_r  <= 1'b1;
      end else begin
         state  <= state_next;
         busy_r <= (state == CLEAR);
         if (state == CLEAR)
            clr_cnt <= clr_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next = state;
      clearing   = 1'b0;
      run        = 1'b0;
      case (state)
         CLEAR: begin
            clearing = 1'b1;
            if (clr_cnt == ADDR_W'(NREGS-1))
               state_next = RUN;
         end
         RUN: run = 1'b1;
         default: state_next = CLEAR;
      endcase
   end

   assign busy     = busy_r;
   assign clr_addr = clr_cnt;
`else
   assign run      = 1'b1;
   assign clearing = 1'b0;
   assign busy     = 1'b0;
   assign clr_addr = '0;
`endif

   assign accept_ok = run && !busy && !rst;

   always_comb begin
      for (int s = 0; s < 2; s++) begin
         rdy[s]      = accept_ok && (q_cnt[s] != 2'd2);
         push[s]     = in_vld[s] && rdy[s];
         head_vld[s] = (q_cnt[s] != 2'd0);
         wr_ptr[s]   = q_rd[s] ^ q_cnt[s][0];
      end
   end

   assign alu_wr_rdy = rdy[0];
   assign mem_wr_rdy = rdy[1];

   assign grant_alu = run && head_vld[0] && (!head_vld[1] || last_grant == SRC_MEM);
   assign grant_mem = run && head_vld[1] && !grant_alu;
   assign grant_src = grant_mem;
   assign pop[0]    = grant_alu;
   assign pop[1]    = grant_mem;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < 2; s++) begin
            q_cnt[s] <= 2'd0;
            q_rd[s]  <= 1'b0;
         end
      end else begin
         for (int s = 0; s < 2; s++) begin
            q_cnt[s] <= q_cnt[s] + {1'b0, push[s]} - {1'b0, pop[s]};
            if (pop[s])
               q_rd[s] <= ~q_rd[s];
         end
      end
   end

   // queue storage needs no reset; validity comes from q_cnt
   always_ff @(posedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (push[s]) begin
            q_addr[s][wr_ptr[s]] <= in_addr[s];
            q_data[s][wr_ptr[s]] <= in_data[s];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we       <= 1'b0;
         rf_dst_addr <= '0;
         rf_dst      <= '0;
         last_grant  <= SRC_MEM;
      end else if (clearing) begin
         rf_we       <= 1'b1;
         rf_dst_addr <= clr_addr;
         rf_dst      <= '0;
      end else if (grant_alu || grant_mem) begin
         rf_we       <= 1'b1;
         rf_dst_addr <= q_addr[grant_src][q_rd[grant_src]];
         rf_dst      <= q_data[grant_src][q_rd[grant_src]];
         last_grant  <= grant_src;
      end else begin
         rf_we <= 1'b0;
      end
   end

   always_comb begin
      pend = '0;
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 2; i++) begin
            if (q_cnt[s] == 2'd2 || (q_cnt[s] == 2'd1 && q_rd[s] == i[0]))
               pend[q_addr[s][i]] = 1'b1;
         end
      end
      if (rf_we)
         pend[rf_dst_addr] = 1'b1;
   end

endmodule

// File: doc/rf_write_ctrl.md
# rf_write_ctrl

Write-port controller for the 16-entry x 16-bit register file in the 5-stage pipeline. Two writeback sources share the file's single write port (dst/dst_addr/WE): ALU writeback and memory writeback. Each source has a 2-entry queue, the two queue heads are granted round-robin, and a per-register pending mask is exported for the hazard unit. After reset, an optional sweep clears every register to zero before normal operation starts.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 4, register address width
- NREGS, 16, register count (2**ADDR_W)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- alu_wr_vld  in  1  ALU write request
- alu_wr_addr  in  ADDR_W  ALU destination register
- alu_wr_data  in  DATA_W  ALU write data
- alu_wr_rdy  out  1  ALU queue can accept
- mem_wr_vld  in  1  memory write request
- mem_wr_addr  in  ADDR_W  memory destination register
- mem_wr_data  in  DATA_W  memory write data
- mem_wr_rdy  out  1  memory queue can accept
- rf_we  out  1  register-file write enable, registered
- rf_dst_addr  out  ADDR_W  register-file write address, registered
- rf_dst  out  DATA_W  register-file write data, registered
- pend  out  NREGS  bit r set while any queued or staged write targets register r
- busy  out  1  clear sweep in progress

## Operation
- States: CLEAR and RUN. Without RF_CLEAR_EN, only RUN exists.
- Handshake: a write is accepted at the edge where vld && rdy. It is pushed into that source's 2-entry FIFO.
- rdy = !full && state==RUN. There is no pass-through when full: a pop and a push in the same cycle do not make a full queue ready.
- Arbitration runs each RUN cycle over the two FIFO heads:
  - One head valid: grant it.
  - Both heads valid: grant the source not granted last time.
  - Register last_grant updates on every grant.
- A grant pops that head at the edge and loads rf_we=1, rf_dst_addr, rf_dst. With no grant, rf_we=0 and addr/data hold their previous values.
- Each FIFO keeps its own writes in order. Between sources, order is arbitration order. The hazard unit must use pend to avoid issuing conflicting same-register writes from both sources.
- pend = OR of one-hot(addr) over all valid FIFO entries, plus one-hot(rf_dst_addr) when rf_we=1. It is combinational from state.
- CLEAR:
  - A 4-bit counter drives rf_we=1, rf_dst=0, rf_dst_addr=counter, over addresses 0..NREGS-1.
  - After address NREGS-1 is issued, move to RUN.
  - busy=1 and both rdy=0 throughout CLEAR.

## Timing
- Reset values:
  - Both FIFOs empty; last_grant=MEM, so the ALU wins the first tie.
  - rf_we=0, rf_dst_addr=0, rf_dst=0, pend=0.
  - State is CLEAR with counter=0 (macro on) or RUN (macro off).
  - busy=1 (macro on) or 0 (macro off).
  - alu_wr_rdy = mem_wr_rdy = 0 during reset.
- Latency: accept at edge k. The head is granted in cycle k..k+1 (or later if it loses arbitration). rf_we is high in the cycle after edge k+1. The register file latches the write at edge k+2, so the minimum latency is 2 cycles.
- Throughput: one write per cycle total. Sustained dual-source traffic gives each source 1 write every 2 cycles.
- Pend: the bit for a write rises the cycle after acceptance. It falls the cycle after rf_we for that write, unless another queued or staged write targets the same register.
- Full queue: rdy is low for the whole cycle in which the queue is full, even if a pop occurs.
- CLEAR timing: first clear write (addr 0) has rf_we=1 in the first cycle after rst falls. The sweep lasts exactly NREGS cycles. busy falls, and rdy may rise, in the cycle after the addr-15 write is presented.
- Reset mid-sweep or mid-traffic: FIFOs flush (pending writes are discarded) and the sweep restarts at address 0.

## Configuration
- RF_CLEAR_EN defined:
  - The CLEAR state and counter are compiled in.
  - Every reset is followed by 16 zero-writes, with busy high.
- RF_CLEAR_EN undefined:
  - No counter is built.
  - The block enters RUN directly from reset, and busy is tied 0.
  - Register-file contents are undefined until written.

## Test plan
- Macro on, release rst: rf_we=1 for 16 consecutive cycles with addresses 0..15 and data 0x0000. busy=1 throughout, then 0. No rdy before busy falls.
- Single ALU write, addr 3, data 0xBEEF, accepted at edge k: rf_we=1 with addr 3 / 0xBEEF in the cycle after edge k+1. pend[3] is high for exactly 2 cycles.
- Both sources valid every cycle (ALU addrs 1,2,3...; MEM addrs 8,9,10...):
  - Commits alternate ALU 1, MEM 8, ALU 2, MEM 9, and so on.
  - Each rdy drops once its queue fills.
  - No write is lost or reordered within a source.
- MEM valid with rf stalled by ALU priority: third MEM push with its queue full (2 entries) sees mem_wr_rdy=0. The data is accepted only after a pop.
- Both queues full with writes to addrs 4, 5, 6, 7: pend=0x00F0. Assert rst mid-stream: pend=0, rf_we=0, and the sweep restarts at addr 0 (macro on) or traffic resumes at once (macro off).
- Macro off, release rst: busy=0, rf_we=0, and rdy=1 in the first cycle after reset.
